// File: rtl/pcs_pkg.sv
// Shared 64b/66b PCS definitions: x^58 + x^39 + 1 LFSR geometry, sync header
// codes, block beat state and the LFSR helpers used by scrambler and descrambler.
package pcs_pkg;
  localparam int LFSR_W = 58;
  localparam int TAP_HI = 57;
  localparam int TAP_LO = 38;

  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CTRL = 2'b10;

  typedef enum logic {
    BEAT0 = 1'b0,
    BEAT1 = 1'b1
  } beat_e;

  function automatic logic lfsr_tap(input logic [LFSR_W-1:0] s);
    return s[TAP_HI] ^ s[TAP_LO];
  endfunction

  // The caller chooses the feedback bit: scrambled output on transmit, received bit on receive.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s, input logic fb);
    return {s[LFSR_W-2:0], fb};
  endfunction
endpackage

// File: rtl/descrambler.sv
// Self-synchronising 64b/66b payload descrambler with priming-based lock flag
// and sync-header / block-cadence error pulses; one cycle of latency.
module descrambler
  import pcs_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter bit DESCRAMBLER_BYPASS = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_data_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_hdr_valid,
  input  logic [1:0]            i_hdr,
  input  logic                  i_lock_lost,
  output logic                  o_data_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_hdr_valid,
  output logic [1:0]            o_hdr,
  output logic                  o_locked,
  output logic                  o_hdr_err,
  output logic                  o_align_err
);
  localparam logic [1:0] PRIME_FULL = 2'd2;

  logic [LFSR_W-1:0]     lfsr_q, lfsr_d, lfsr_walk;
  logic [DATA_WIDTH-1:0] plain;
  logic [1:0]            prime_q, prime_d;
  beat_e                 beat_q, beat_d, beat_cur;
  logic                  align_bad, hdr_bad;

  logic                  data_valid_q, hdr_valid_q, locked_q, hdr_err_q, align_err_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [1:0]            hdr_q;

  // Received bits feed the LFSR, so a wrong start state flushes out after 58 bits.
  always_comb begin
    lfsr_walk = lfsr_q;
    plain     = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      plain[i]  = i_data[i] ^ lfsr_tap(lfsr_walk);
      lfsr_walk = lfsr_step(lfsr_walk, i_data[i]);
    end
    lfsr_d = i_data_valid ? lfsr_walk : lfsr_q;
  end

  always_comb begin
    prime_d = prime_q;
    if (i_lock_lost) begin
      prime_d = i_data_valid ? 2'd1 : 2'd0;
    end else if (i_data_valid && (prime_q != PRIME_FULL)) begin
      prime_d = prime_q + 2'd1;
    end
  end

  // A word coincident with lock loss is judged as the first word of a new block.
  always_comb begin
    beat_cur  = i_lock_lost ? BEAT0 : beat_q;
    beat_d    = beat_cur;
    align_bad = 1'b0;
    if (i_data_valid) begin
      beat_d    = i_hdr_valid ? BEAT1 : BEAT0;
      align_bad = i_hdr_valid ^ (beat_cur == BEAT0);
    end
  end

  assign hdr_bad = i_data_valid && i_hdr_valid && (i_hdr != HDR_DATA) && (i_hdr != HDR_CTRL);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      lfsr_q       <= '1;
      prime_q      <= '0;
      beat_q       <= BEAT0;
      data_valid_q <= 1'b0;
      data_q       <= '0;
      hdr_valid_q  <= 1'b0;
      hdr_q        <= '0;
      locked_q     <= 1'b0;
      hdr_err_q    <= 1'b0;
      align_err_q  <= 1'b0;
    end else begin
      lfsr_q       <= lfsr_d;
      prime_q      <= prime_d;
      beat_q       <= beat_d;
      data_valid_q <= i_data_valid;
      hdr_valid_q  <= i_data_valid & i_hdr_valid;
      hdr_err_q    <= hdr_bad;
      align_err_q  <= align_bad;
      locked_q     <= DESCRAMBLER_BYPASS ? 1'b1 : (prime_d == PRIME_FULL);
      if (i_data_valid) begin
        data_q <= DESCRAMBLER_BYPASS ? i_data : plain;
        hdr_q  <= i_hdr;
      end
    end
  end

  assign o_data_valid = data_valid_q;
  assign o_data       = data_q;
  assign o_hdr_valid  = hdr_valid_q;
  assign o_hdr        = hdr_q;
  assign o_locked     = locked_q;
  assign o_hdr_err    = hdr_err_q;
  assign o_align_err  = align_err_q;
endmodule

// File: tb/tb_descrambler.sv
// Bench for descrambler: a reference scrambler feeds the DUT and the plaintext is
// queued as the expected output; a second instance covers bypass mode.
module tb_descrambler;
  typedef struct packed {
    logic        dv;
    logic [31:0] data;
    logic        hv;
    logic [1:0]  hdr;
    logic        herr;
    logic        aerr;
  } exp_t;

  // {valid, hdr_valid, hdr[1:0], lock_lost, hdr_err, align_err, locked}
  typedef struct packed {
    logic       v;
    logic       hv;
    logic [1:0] hdr;
    logic       ll;
    logic       herr;
    logic       aerr;
    logic       lock;
  } row_t;

  logic        clk       = 1'b0;
  logic        resetN    = 1'b1;
  logic        dataValid = 1'b0;
  logic [31:0] dataIn    = '0;
  logic        hdrValid  = 1'b0;
  logic [1:0]  hdrIn     = '0;
  logic        lockLost  = 1'b0;

  logic        oDataValid, oHdrValid, oLocked, oHdrErr, oAlignErr;
  logic [31:0] oData;
  logic [1:0]  oHdr;
  logic        bDataValid, bHdrValid, bLocked, bHdrErr, bAlignErr;
  logic [31:0] bData;
  logic [1:0]  bHdr;

  logic [37:0] obs, bObs;
  assign obs  = {oDataValid, oData, oHdrValid, oHdr, oHdrErr, oAlignErr};
  assign bObs = {bDataValid, bData, bHdrValid, bHdr, bHdrErr, bAlignErr};

  int          tests  = 0;
  int          failed = 0;
  exp_t        sb[$];
  logic [57:0] scr      = '1;
  logic [31:0] lastData = '0;
  logic [1:0]  lastHdr  = '0;

  always #5 clk = ~clk;

  descrambler #(.DATA_WIDTH(32), .DESCRAMBLER_BYPASS(1'b0)) dut (
    .i_clk(clk), .i_reset_n(resetN), .i_data_valid(dataValid), .i_data(dataIn),
    .i_hdr_valid(hdrValid), .i_hdr(hdrIn), .i_lock_lost(lockLost),
    .o_data_valid(oDataValid), .o_data(oData), .o_hdr_valid(oHdrValid), .o_hdr(oHdr),
    .o_locked(oLocked), .o_hdr_err(oHdrErr), .o_align_err(oAlignErr)
  );

  descrambler #(.DATA_WIDTH(32), .DESCRAMBLER_BYPASS(1'b1)) byp (
    .i_clk(clk), .i_reset_n(resetN), .i_data_valid(dataValid), .i_data(dataIn),
    .i_hdr_valid(hdrValid), .i_hdr(hdrIn), .i_lock_lost(lockLost),
    .o_data_valid(bDataValid), .o_data(bData), .o_hdr_valid(bHdrValid), .o_hdr(bHdr),
    .o_locked(bLocked), .o_hdr_err(bHdrErr), .o_align_err(bAlignErr)
  );

  task automatic scramble(input logic [31:0] p, output logic [31:0] s);
    for (int i = 0; i < 32; i++) begin
      s[i] = p[i] ^ scr[57] ^ scr[38];
      scr  = {scr[56:0], s[i]};
    end
  endtask

  task automatic do_reset();
    dataValid = 1'b0;
    hdrValid  = 1'b0;
    lockLost  = 1'b0;
    resetN    = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    scr      = '1;
    lastData = '0;
    lastHdr  = '0;
    sb.delete();
  endtask

  // Drives one cycle and queues what the DUT must show one cycle later.
  task automatic step(input logic v, input logic raw, input logic [31:0] plain,
                      input logic [31:0] expRaw, input logic hv, input logic [1:0] hdr,
                      input logic ll, input logic herr, input logic aerr);
    logic [31:0] line;
    exp_t        e;
    line = plain;
    if (v) begin
      if (!raw) scramble(plain, line);
      lastData = raw ? expRaw : plain;
      lastHdr  = hdr;
    end
    e.dv   = v;
    e.data = lastData;
    e.hv   = v & hv;
    e.hdr  = lastHdr;
    e.herr = herr;
    e.aerr = aerr;
    sb.push_back(e);
    dataValid = v;
    dataIn    = line;
    hdrValid  = hv;
    hdrIn     = hdr;
    lockLost  = ll;
    @(posedge clk);
    #1;
    dataValid = 1'b0;
    hdrValid  = 1'b0;
    lockLost  = 1'b0;
  endtask

  task automatic test_reset();
    #2 resetN = 1'b0;
    #1;
    tests++;
    if ({obs, oLocked} !== 39'd0) begin
      failed++;
      $display("[TB] FAIL reset_outputs: got %h want 0", {obs, oLocked});
    end
    tests++;
    if ({bObs, bLocked} !== 39'd0) begin
      failed++;
      $display("[TB] FAIL reset_bypass_outputs: got %h want 0", {bObs, bLocked});
    end
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (bLocked !== 1'b1) begin
      failed++;
      $display("[TB] FAIL bypass_lock_after_reset: got %b want 1", bLocked);
    end
    tests++;
    if (oLocked !== 1'b0) begin
      failed++;
      $display("[TB] FAIL unprimed_lock: got %b want 0", oLocked);
    end
  endtask

  task automatic test_zero_words();
    exp_t e;
    do_reset();
    step(1'b1, 1'b1, 32'h0, 32'h0000_0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front();
    tests++;
    if (obs !== e) begin
      failed++;
      $display("[TB] FAIL zero_word0: got %h want %h", obs, e);
    end
    tests++;
    if (oLocked !== 1'b0) begin
      failed++;
      $display("[TB] FAIL zero_lock0: got %b want 0", oLocked);
    end
    step(1'b1, 1'b1, 32'h0, 32'h03FF_FF80, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front();
    tests++;
    if (obs !== e) begin
      failed++;
      $display("[TB] FAIL zero_word1: got %h want %h", obs, e);
    end
    tests++;
    if (oLocked !== 1'b1) begin
      failed++;
      $display("[TB] FAIL zero_lock1: got %b want 1", oLocked);
    end
  endtask

  task automatic test_loopback();
    exp_t       e;
    logic       hv;
    logic [1:0] hdr;
    do_reset();
    for (int k = 0; k < 1000; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        step(1'b0, 1'b0, $urandom(), 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front();
        tests++;
        if (obs !== e) begin
          failed++;
          $display("[TB] FAIL loopback_idle %0d: got %h want %h", k, obs, e);
        end
      end
      hv  = (k % 2 == 0);
      hdr = hv ? (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10) : 2'($urandom_range(0, 3));
      step(1'b1, 1'b0, $urandom(), 32'h0, hv, hdr, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        failed++;
        $display("[TB] FAIL loopback_word %0d: got %h want %h", k, obs, e);
      end
    end
    tests++;
    if (oLocked !== 1'b1) begin
      failed++;
      $display("[TB] FAIL loopback_lock: got %b want 1", oLocked);
    end
  endtask

  task automatic test_random_seed();
    exp_t        e;
    logic [63:0] r;
    logic [31:0] dmask;
    logic [37:0] mask;
    do_reset();
    r   = {$urandom(), $urandom()};
    scr = r[57:0];
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, $urandom(), 32'h0, (k % 2 == 0), (k % 2 == 0) ? 2'b10 : 2'b00,
           1'b0, 1'b0, 1'b0);
      e     = sb.pop_front();
      dmask = (k == 0) ? 32'h0 : (k == 1) ? 32'hFC00_0000 : 32'hFFFF_FFFF;
      mask  = {1'b1, dmask, 5'b11111};
      tests++;
      if ((obs & mask) !== (e & mask)) begin
        failed++;
        $display("[TB] FAIL seed_word %0d: got %h want %h (mask %h)", k, obs, e, mask);
      end
      tests++;
      if (oLocked !== (k >= 1)) begin
        failed++;
        $display("[TB] FAIL seed_lock %0d: got %b want %b", k, oLocked, (k >= 1));
      end
    end
  endtask

  task automatic test_hdr_errors();
    exp_t e;
    row_t rows [10];
    rows = '{8'b1_1_00_0_1_0_0, 8'b1_0_11_0_0_0_0, 8'b1_1_11_0_1_0_0, 8'b1_0_00_0_0_0_0,
             8'b0_1_11_0_0_0_0, 8'b1_1_01_0_0_0_0, 8'b1_1_10_0_0_1_0, 8'b1_0_01_0_0_0_0,
             8'b1_0_10_0_0_1_0, 8'b1_1_10_0_0_0_0};
    // A reset in the middle of a block must leave the tracker expecting a header.
    do_reset();
    step(1'b1, 1'b0, $urandom(), 32'h0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    tests++;
    if (obs !== e) begin
      failed++;
      $display("[TB] FAIL hdr_preblock: got %h want %h", obs, e);
    end
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step(rows[k].v, 1'b0, $urandom(), 32'h0, rows[k].hv, rows[k].hdr, rows[k].ll,
           rows[k].herr, rows[k].aerr);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        failed++;
        $display("[TB] FAIL hdr_row %0d: got %h want %h", k, obs, e);
      end
    end
  endtask

  task automatic test_lock_lost();
    exp_t e;
    row_t rows [8];
    rows = '{8'b1_1_01_0_0_0_0, 8'b1_0_00_0_0_0_1, 8'b1_1_10_0_0_0_1, 8'b0_0_00_1_0_0_0,
             8'b1_1_01_0_0_0_0, 8'b1_0_00_0_0_0_1, 8'b1_1_10_1_0_0_0, 8'b1_0_00_0_0_0_1};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(rows[k].v, 1'b0, $urandom(), 32'h0, rows[k].hv, rows[k].hdr, rows[k].ll,
           rows[k].herr, rows[k].aerr);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        failed++;
        $display("[TB] FAIL lock_row %0d: got %h want %h", k, obs, e);
      end
      tests++;
      if (oLocked !== rows[k].lock) begin
        failed++;
        $display("[TB] FAIL lock_flag %0d: got %b want %b", k, oLocked, rows[k].lock);
      end
    end
  endtask

  task automatic test_bypass();
    do_reset();
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    sb.delete();
    tests++;
    if (bObs !== {1'b1, 32'hDEAD_BEEF, 1'b1, 2'b01, 2'b00}) begin
      failed++;
      $display("[TB] FAIL bypass_word0: got %h want %h", bObs,
               {1'b1, 32'hDEAD_BEEF, 1'b1, 2'b01, 2'b00});
    end
    step(1'b1, 1'b1, 32'h1234_5678, 32'h1234_5678, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
    sb.delete();
    tests++;
    if (bObs !== {1'b1, 32'h1234_5678, 1'b0, 2'b10, 2'b00}) begin
      failed++;
      $display("[TB] FAIL bypass_word1: got %h want %h", bObs,
               {1'b1, 32'h1234_5678, 1'b0, 2'b10, 2'b00});
    end
    step(1'b0, 1'b1, 32'hFFFF_0000, 32'h0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
    sb.delete();
    tests++;
    if ({bObs, bLocked} !== {1'b0, 32'h1234_5678, 1'b0, 2'b10, 2'b00, 1'b1}) begin
      failed++;
      $display("[TB] FAIL bypass_hold: got %h want %h", {bObs, bLocked},
               {1'b0, 32'h1234_5678, 1'b0, 2'b10, 2'b00, 1'b1});
    end
  endtask

  initial begin
    test_reset();
    test_zero_words();
    test_loopback();
    test_random_seed();
    test_hdr_errors();
    test_lock_lost();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/descrambler.md
DESCRAMBLER -- requirements
Module: descrambler

Interface
REQ-001 Parameter DATA_WIDTH, default 32, datapath width; only 32 is supported.
REQ-002 Parameter DESCRAMBLER_BYPASS, default 0, when 1 data passes through with no descrambling.
REQ-003 i_clk  in  1  single clock; all logic rises on this edge.
REQ-004 i_reset_n  in  1  asynchronous active-low reset.
REQ-005 i_data_valid  in  1  i_data carries a scrambled payload word this cycle.
REQ-006 i_data  in  32  scrambled payload word; bit 0 is first on the line.
REQ-007 i_hdr_valid  in  1  i_hdr is valid; asserted only on the first word of a 66-bit block.
REQ-008 i_hdr  in  2  block sync header from block lock/gearbox.
REQ-009 i_lock_lost  in  1  block lock dropped; resynchronise the descrambler.
REQ-010 o_data_valid  out  1  o_data valid.
REQ-011 o_data  out  32  descrambled payload word.
REQ-012 o_hdr_valid  out  1  o_hdr valid, aligned with the first word of the block.
REQ-013 o_hdr  out  2  sync header, passed through unmodified.
REQ-014 o_locked  out  1  LFSR primed by at least 58 received bits since the last reset or lock loss.
REQ-015 o_hdr_err  out  1  one-cycle pulse when a header is 2'b00 or 2'b11.
REQ-016 o_align_err  out  1  one-cycle pulse when the header position violates the two-word block cadence.

Function
REQ-017 The block SHALL descramble per x^58+x^39+1 self-synchronising: for i=0..31, out[i]=in[i]^s[57]^s[38], then s={s[56:0],in[i]} (the received bit is shifted in, not the output).
REQ-018 The 58-bit state SHALL advance only on cycles with i_data_valid=1.
REQ-019 Latency SHALL be exactly 1 cycle: o_data_valid, o_data, o_hdr_valid, o_hdr are registered copies of the cycle-N inputs at N+1.
REQ-020 When o_data_valid=0, o_data and o_hdr SHALL hold their previous values.
REQ-021 With DESCRAMBLER_BYPASS=1, o_data SHALL equal i_data (1-cycle delay), and o_locked SHALL be 1 one cycle after reset release.
REQ-022 A prime counter (0..2) SHALL increment on each valid word and saturate at 2; o_locked=1 when the count is 2 (registered).
REQ-023 i_lock_lost=1 SHALL clear the prime counter and o_locked the next cycle; the LFSR continues shifting. An i_lock_lost coincident with a valid word means that word counts as the first priming word (count=1).
REQ-024 A beat tracker SHALL hold two states, BEAT0 (expect header) and BEAT1 (expect no header), and advance only on valid words.
REQ-025 BEAT0 with hdr_valid -> BEAT1; BEAT0 without hdr_valid -> pulse o_align_err, stay in BEAT0.
REQ-026 BEAT1 without hdr_valid -> BEAT0; BEAT1 with hdr_valid -> pulse o_align_err, treat the word as BEAT0 and go to BEAT1.
REQ-027 i_lock_lost SHALL force BEAT0.
REQ-028 o_hdr_err SHALL pulse with the output word whose header is 00/11, independent of the beat state; i_hdr_valid without i_data_valid is ignored.
REQ-029 Error pulses SHALL be registered and aligned with o_data_valid of the offending word.

Reset
REQ-030 On i_reset_n=0, asynchronously: LFSR all ones; prime counter 0; beat BEAT0; all outputs 0.
REQ-031 Reset during a block SHALL discard that block; the first valid word after release is treated as BEAT0.

Structure
REQ-032 A shared package pcs_pkg SHALL hold the LFSR width (58), the tap indices (57, 38), the sync header constants (HDR_DATA=2'b01, HDR_CTRL=2'b10) and the beat-state enum.
REQ-033 The descrambler SHALL be a single module with no sub-modules; LFSR stepping is a function in pcs_pkg shared with the scrambler.

Verification
REQ-034 Reset, then two valid words 0x00000000 with no header -> o_data 0x00000000 then 0x03FFFF80; o_locked rises after the second output.
REQ-035 Scrambler->descrambler loopback, 1000 random words with header cadence 01/10 -> o_data equals the scrambler input with 1-cycle latency; no error pulses.
REQ-036 Scrambler seeded with random state, descrambler reset -> output mismatches confined to the first 58 bits; matches from word 2 onward, and o_locked=1.
REQ-037 Headers 2'b00 then 2'b11 on BEAT0 words -> two o_hdr_err pulses; hdr_valid on a BEAT1 word -> one o_align_err pulse, and the next word is BEAT1.
REQ-038 i_lock_lost pulsed mid-stream -> o_locked=0 next cycle, re-asserts after two valid words; beat restarts at BEAT0.
REQ-039 DESCRAMBLER_BYPASS=1, word 0xDEADBEEF -> o_data 0xDEADBEEF one cycle later.
